// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_e        : FSM encoding (IDLE, ISSUE, WAIT, ACK)
//   OWN_CPU / OWN_DBG  : owner encoding for the two requesters
//   MEM_LAT_MIN/MAX    : legal range of the memory read latency
//   LAT_CNT_W          : latency counter width, sized for MEM_LAT_MAX
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_ACK   = 2'b11
    } arb_state_e;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 7;
    localparam int LAT_CNT_W   = 3;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Combinational grant picker for the two memory requesters.
// Build option: MEM_ARB_CPU_PRIORITY_EN -- when defined the CPU always wins
// a contention and last_owner is ignored; otherwise contention is resolved
// round-robin (the requester that was not granted last wins).
// Ports:
//   cpu_req, dbg_req : request bits
//   last_owner       : owner of the most recently completed access
//   grant_valid      : at least one request is pending
//   grant_owner      : OWN_CPU or OWN_DBG, meaningful when grant_valid
module mem_arb_rr_pick
    import mem_arb_pkg::*;
(
    input  logic cpu_req,
    input  logic dbg_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

`ifdef MEM_ARB_CPU_PRIORITY_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant_valid = cpu_req | dbg_req;
        grant_owner = OWN_CPU;
        if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
            grant_owner = OWN_CPU;
`else
            grant_owner = (last_owner == OWN_CPU) ? OWN_DBG : OWN_CPU;
`endif
        end else if (dbg_req) begin
            grant_owner = OWN_DBG;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory between the CPU memory path and a debug /
// loader port. Each access runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK.
// Build option: MEM_ARB_CPU_PRIORITY_EN (see mem_arb_rr_pick).
// Ports:
//   clk, reset (async, active-low)
//   cpu_* : CPU requester (req/we/addr/wdata in, rdata/ack/stall out)
//   dbg_* : debug requester (req/we/addr/wdata in, rdata/ack out)
//   mem_* : memory side (en/we/addr/wdata out, rdata in)
//   fsm_state : current arbiter state, for observation
//
// Handshake: a requester raises req with we/addr/wdata and holds them stable
// until ack, which is high for exactly one cycle. req may stay high after ack
// to ask for the next access. Requests are only sampled in IDLE; once an
// access is issued it always runs to its ack, even if req drops.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        fsm_state
);

    arb_state_e            state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic                  last_owner_q, last_owner_d;
    logic [DATA_W-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]     dbg_rdata_q, dbg_rdata_d;
    logic                  grant_valid, grant_owner;
    logic                  wait_done;

    mem_arb_rr_pick u_pick (
        .cpu_req     (cpu_req),
        .dbg_req     (dbg_req),
        .last_owner  (last_owner_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // The counter holds MEM_LAT in the first WAIT cycle and 1 in the last,
    // so WAIT lasts exactly MEM_LAT cycles and the read data is taken on the
    // edge that leaves WAIT.
    assign wait_done = (state_q == ST_WAIT) && (cnt_q == LAT_CNT_W'(1));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (grant_valid) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (wait_done) state_d = ST_ACK;
            ST_ACK:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        mem_en    = (state_q == ST_ISSUE);
        mem_we    = (state_q == ST_ISSUE) && we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        cpu_ack   = (state_q == ST_ACK) && (owner_q == OWN_CPU);
        dbg_ack   = (state_q == ST_ACK) && (owner_q == OWN_DBG);
        cpu_stall = cpu_req && !cpu_ack;
        cpu_rdata = cpu_rdata_q;
        dbg_rdata = dbg_rdata_q;
        fsm_state = state_q;
    end

    // Datapath next values: capture the winner's request, run the latency
    // counter, land read data in the owner's port register.
    always_comb begin
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        last_owner_d = last_owner_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    if (grant_owner == OWN_CPU) begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        we_d    = dbg_we;
                        addr_d  = dbg_addr;
                        wdata_d = dbg_wdata;
                    end
                end
            end
            ST_ISSUE: cnt_d = LAT_CNT_W'(MEM_LAT);
            ST_WAIT: begin
                cnt_d = cnt_q - LAT_CNT_W'(1);
                if (wait_done && !we_q) begin
                    if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                    else                    dbg_rdata_d = mem_rdata;
                end
            end
            ST_ACK:  last_owner_d = owner_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_CPU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            last_owner_q <= OWN_DBG;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            last_owner_q <= last_owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 16;
    localparam int MEM_LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack, cpu_stall;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [ADDR_W-1:0] dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0]        fsm_state;

    mem_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .fsm_state(fsm_state)
    );

    // ---------------- memory stub: MEM_LAT-deep read pipeline ----------------
    logic [DATA_W-1:0] mem_arr [1<<ADDR_W];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    always @(posedge clk) begin
        if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_arr[mem_addr];
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // ---------------- checking infrastructure ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An access granted in cycle g strobes the memory in g+1, delivers read
    // data on the edge ending g+MEM_LAT+1 and acks in g+MEM_LAT+2; the next
    // grant can happen no earlier than the cycle after the ack.
    bit                m_busy = 1'b0;
    int                m_g = 0;
    bit                m_owner = 1'b0;   // 0 = CPU, 1 = DBG
    bit                m_we = 1'b0;
    bit                m_last = 1'b1;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic [DATA_W-1:0] m_data = '0;
    logic [DATA_W-1:0] exp_rdata [2];
    logic [DATA_W-1:0] ref_mem [1<<ADDR_W];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            exp_rdata[0] = '0;
            exp_rdata[1] = '0;
        end else begin
            if (m_busy && cyc == m_g + MEM_LAT + 1 && !m_we) exp_rdata[m_owner] = m_data;
            if (m_busy && cyc == m_g + MEM_LAT + 2) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end else if (!m_busy && (cpu_req || dbg_req)) begin
                if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
                    m_owner = 1'b0;
`else
                    m_owner = !m_last;
`endif
                end else begin
                    m_owner = dbg_req;
                end
                m_busy  = 1'b1;
                m_g     = cyc;
                m_we    = m_owner ? dbg_we : cpu_we;
                m_addr  = m_owner ? dbg_addr : cpu_addr;
                m_wdata = m_owner ? dbg_wdata : cpu_wdata;
                if (m_we) ref_mem[m_addr] = m_wdata;
                else      m_data = ref_mem[m_addr];
            end
        end
    end

    // ---------------- scoreboard: per-cycle compare + event logs ----------------
    logic [DATA_W-1:0] exp_q [$];
    int en_q[$], we_q[$], cack_q[$], dack_q[$], stall_q[$];
    logic [ADDR_W-1:0] we_addr_q[$];
    bit e_en, e_ack;

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_cpu_ack", cpu_ack, 0);
            chk("rst_dbg_ack", dbg_ack, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);
            chk("rst_dbg_rdata", dbg_rdata, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
        end else begin
            e_en  = m_busy && (cyc == m_g + 1);
            e_ack = m_busy && (cyc == m_g + MEM_LAT + 2);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_en && m_we);
            if (e_en) begin
                chk("mem_addr", mem_addr, m_addr);
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("cpu_ack", cpu_ack, e_ack && !m_owner);
            chk("dbg_ack", dbg_ack, e_ack && m_owner);
            chk("cpu_stall", cpu_stall, cpu_req && !(e_ack && !m_owner));
            chk("cpu_rdata", cpu_rdata, exp_rdata[0]);
            chk("dbg_rdata", dbg_rdata, exp_rdata[1]);
        end
        if (mem_en)    en_q.push_back(cyc - t0);
        if (mem_we)    begin we_q.push_back(cyc - t0); we_addr_q.push_back(mem_addr); end
        if (cpu_ack)   cack_q.push_back(cyc - t0);
        if (dbg_ack)   dack_q.push_back(cyc - t0);
        if (cpu_stall) stall_q.push_back(cyc - t0);
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        en_q.delete(); we_q.delete(); we_addr_q.delete();
        cack_q.delete(); dack_q.delete(); stall_q.delete();
        t0 = cyc;
    endtask

    task automatic run_to(input int rel);
        while (cyc - t0 < rel) next_cycle();
    endtask

    task automatic drive_cpu(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic drive_dbg(input logic req, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d);
        dbg_req = req; dbg_we = we; dbg_addr = a; dbg_wdata = d;
    endtask

    function automatic int first_or(input int q[$], input int dflt);
        return (q.size() > 0) ? q[0] : dflt;
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem_arr[i] = 32'hA5A5_0000 ^ DATA_W'(i);
            ref_mem[i] = 32'hA5A5_0000 ^ DATA_W'(i);
        end
        mem_arr[16'h0010] = 32'hDEAD_BEEF; ref_mem[16'h0010] = 32'hDEAD_BEEF;
        mem_arr[16'h0030] = 32'hCAFE_F00D; ref_mem[16'h0030] = 32'hCAFE_F00D;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;

        repeat (3) next_cycle();
        reset = 1'b1;
        next_cycle();
        chk("idle_state", fsm_state, 2'b00);

        // CPU read of 0x0010
        start_test();
        drive_cpu(1'b1, 1'b0, 16'h0010, '0);
        run_to(4);
        drive_cpu(1'b0, 1'b0, 16'h0010, '0);
        run_to(7);
        chk("a_en_count", en_q.size(), 1);
        chk("a_en_cycle", first_or(en_q, 999), 1);
        chk("a_ack_cycle", first_or(cack_q, 999), 4);
        chk("a_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("a_stall_len", stall_q.size(), 4);
        chk("a_stall_first", first_or(stall_q, 999), 0);

        // Debug read of 0x0030 so dbg_rdata holds a known non-zero value
        start_test();
        drive_dbg(1'b1, 1'b0, 16'h0030, '0);
        run_to(4);
        drive_dbg(1'b0, 1'b0, 16'h0030, '0);
        run_to(7);
        chk("b0_ack_cycle", first_or(dack_q, 999), 4);
        chk("b0_rdata", dbg_rdata, 32'hCAFE_F00D);

        // Debug write 0x0020 <= 0x12345678
        start_test();
        drive_dbg(1'b1, 1'b1, 16'h0020, 32'h1234_5678);
        run_to(4);
        drive_dbg(1'b0, 1'b0, 16'h0020, '0);
        run_to(7);
        chk("b_we_count", we_q.size(), 1);
        chk("b_we_cycle", first_or(we_q, 999), 1);
        chk("b_we_addr", (we_addr_q.size() > 0) ? we_addr_q[0] : 16'hFFFF, 16'h0020);
        chk("b_ack_cycle", first_or(dack_q, 999), 4);
        chk("b_rdata_kept", dbg_rdata, 32'hCAFE_F00D);

        // CPU reads back the written word
        start_test();
        drive_cpu(1'b1, 1'b0, 16'h0020, '0);
        run_to(4);
        drive_cpu(1'b0, 1'b0, 16'h0020, '0);
        run_to(7);
        chk("c_rdata", cpu_rdata, 32'h1234_5678);

        // Abandoned request: cpu_req dropped in WAIT
        start_test();
        drive_cpu(1'b1, 1'b0, 16'h0030, '0);
        run_to(2);
        drive_cpu(1'b0, 1'b0, 16'h0030, '0);
        run_to(10);
        chk("d_ack_count", cack_q.size(), 1);
        chk("d_ack_cycle", first_or(cack_q, 999), 4);
        chk("d_en_count", en_q.size(), 1);
        chk("d_rdata", cpu_rdata, 32'hCAFE_F00D);

        // Reset during WAIT, then contention with both requests held
        start_test();
        drive_dbg(1'b1, 1'b0, 16'h0010, '0);
        run_to(2);
        drive_cpu(1'b1, 1'b0, 16'h0020, '0);
        #1;
        reset = 1'b0;
        #1;
        chk("e_rst_mem_en", mem_en, 0);
        chk("e_rst_cpu_ack", cpu_ack, 0);
        chk("e_rst_dbg_ack", dbg_ack, 0);
        chk("e_rst_cpu_rdata", cpu_rdata, 0);
        chk("e_rst_dbg_rdata", dbg_rdata, 0);
        chk("e_rst_state", fsm_state, 2'b00);
        next_cycle();
        next_cycle();
        reset = 1'b1;
        start_test();
        run_to(15);
        drive_cpu(1'b0, 1'b0, '0, '0);
        drive_dbg(1'b0, 1'b0, '0, '0);
        run_to(19);
        chk("f_en_count", en_q.size(), 3);
        chk("f_cpu_ack0", first_or(cack_q, 999), 4);
`ifdef MEM_ARB_CPU_PRIORITY_EN
        chk("f_cpu_acks", cack_q.size(), 3);
        chk("f_dbg_acks", dack_q.size(), 0);
        chk("f_cpu_ack2", (cack_q.size() > 2) ? cack_q[2] : 999, 14);
        chk("f_dbg_rdata", dbg_rdata, 0);
`else
        chk("f_cpu_acks", cack_q.size(), 2);
        chk("f_dbg_acks", dack_q.size(), 1);
        chk("f_dbg_ack0", first_or(dack_q, 999), 9);
        chk("f_cpu_ack1", (cack_q.size() > 1) ? cack_q[1] : 999, 14);
        chk("f_dbg_rdata", dbg_rdata, 32'hDEAD_BEEF);
`endif
        chk("f_cpu_rdata", cpu_rdata, 32'h1234_5678);

        // ---------------- final report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
